// File: rtl/fractal_sync_node_rf.sv
// rtl/fractal_sync_node_rf.sv - N-child fractal sync node: barrier aggregation table, RR arbiter, up/down outputs
module fractal_sync_node_rf #(
   parameter int N_CHILD  = 2,
   parameter int LVL_W    = 4,
   parameter int ID_W     = 4,
   parameter int NODE_LVL = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [N_CHILD-1:0]         req_valid_i,
   output logic [N_CHILD-1:0]         req_ready_o,
   input  logic [N_CHILD*LVL_W-1:0]   req_lvl_i,
   input  logic [N_CHILD*ID_W-1:0]    req_id_i,
   input  logic [N_CHILD*N_CHILD-1:0] req_sd_i,
   output logic                       up_valid_o,
   input  logic                       up_ready_i,
   output logic [LVL_W-1:0]           up_lvl_o,
   output logic [ID_W-1:0]            up_id_o,
   output logic                       dn_valid_o,
   input  logic                       dn_ready_i,
   output logic [N_CHILD-1:0]         dn_mask_o,
   output logic [LVL_W-1:0]           dn_lvl_o,
   output logic [ID_W-1:0]            dn_id_o,
   output logic                       err_o,
   output logic [ID_W-1:0]            err_id_o
);
   localparam int DEPTH = 1 << ID_W;
   localparam int PTR_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
   localparam logic [LVL_W-1:0] NODE_LVL_L = LVL_W'(NODE_LVL);

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [DEPTH-1:0]   tv_q, tv_d;
   logic [LVL_W-1:0]   tl_q [DEPTH];
   logic [LVL_W-1:0]   tl_d [DEPTH];
   logic [N_CHILD-1:0] te_q [DEPTH];
   logic [N_CHILD-1:0] te_d [DEPTH];
   logic [N_CHILD-1:0] ta_q [DEPTH];
   logic [N_CHILD-1:0] ta_d [DEPTH];

   logic               up_valid_q, up_valid_d;
   logic [LVL_W-1:0]   up_lvl_q, up_lvl_d;
   logic [ID_W-1:0]    up_id_q, up_id_d;
   logic               dn_valid_q, dn_valid_d;
   logic [N_CHILD-1:0] dn_mask_q, dn_mask_d;
   logic [LVL_W-1:0]   dn_lvl_q, dn_lvl_d;
   logic [ID_W-1:0]    dn_id_q, dn_id_d;
   logic               err_q, err_d;
   logic [ID_W-1:0]    err_id_q, err_id_d;

   logic               stall, gnt_any, bad, done;
   logic [PTR_W-1:0]   gnt_idx;
   logic [N_CHILD-1:0] gnt_oh, r_sd, new_arr;
   logic [LVL_W-1:0]   r_lvl;
   logic [ID_W-1:0]    r_id;
   int                 cand;

   assign stall = (up_valid_q & ~up_ready_i) | (dn_valid_q & ~dn_ready_i);

   // Round-robin scan starting at ptr_q; first valid child wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int i = 0; i < N_CHILD; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= N_CHILD) cand = cand - N_CHILD;
         if (!stall && !gnt_any && req_valid_i[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(cand);
         end
      end
   end

   assign gnt_oh      = gnt_any ? (N_CHILD'(1) << gnt_idx) : '0;
   assign req_ready_o = gnt_oh;
   assign r_lvl       = req_lvl_i[gnt_idx*LVL_W +: LVL_W];
   assign r_id        = req_id_i[gnt_idx*ID_W +: ID_W];
   assign r_sd        = req_sd_i[gnt_idx*N_CHILD +: N_CHILD];
   assign new_arr     = (tv_q[r_id] ? ta_q[r_id] : '0) | gnt_oh;
   assign done        = (new_arr == r_sd);
   assign bad = (r_lvl < NODE_LVL_L) || (r_sd == '0) || !r_sd[gnt_idx]
             || (tv_q[r_id] && ((r_lvl != tl_q[r_id]) || (r_sd != te_q[r_id])))
             || (tv_q[r_id] && ((ta_q[r_id] & gnt_oh) != '0));

   always_comb begin
      ptr_d      = ptr_q;
      tv_d       = tv_q;
      tl_d       = tl_q;
      te_d       = te_q;
      ta_d       = ta_q;
      up_valid_d = up_valid_q & ~up_ready_i;
      up_lvl_d   = up_lvl_q;
      up_id_d    = up_id_q;
      dn_valid_d = dn_valid_q & ~dn_ready_i;
      dn_mask_d  = dn_mask_q;
      dn_lvl_d   = dn_lvl_q;
      dn_id_d    = dn_id_q;
      err_d      = 1'b0;
      err_id_d   = err_id_q;
      if (gnt_any) begin
         ptr_d = (int'(gnt_idx) == N_CHILD - 1) ? '0 : gnt_idx + 1'b1;
         if (bad) begin
            err_d    = 1'b1;
            err_id_d = r_id;
         end else if (done) begin
            tv_d[r_id] = 1'b0;
            // Levels below NODE_LVL were rejected above, so anything not ours goes up.
            if (r_lvl == NODE_LVL_L) begin
               dn_valid_d = 1'b1;
               dn_mask_d  = r_sd;
               dn_lvl_d   = r_lvl;
               dn_id_d    = r_id;
            end else begin
               up_valid_d = 1'b1;
               up_lvl_d   = r_lvl;
               up_id_d    = r_id;
            end
         end else begin
            tv_d[r_id] = 1'b1;
            tl_d[r_id] = r_lvl;
            te_d[r_id] = r_sd;
            ta_d[r_id] = new_arr;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
         tv_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tl_q[i] <= '0;
            te_q[i] <= '0;
            ta_q[i] <= '0;
         end
         up_valid_q <= 1'b0;
         up_lvl_q   <= '0;
         up_id_q    <= '0;
         dn_valid_q <= 1'b0;
         dn_mask_q  <= '0;
         dn_lvl_q   <= '0;
         dn_id_q    <= '0;
         err_q      <= 1'b0;
         err_id_q   <= '0;
      end else begin
         ptr_q      <= ptr_d;
         tv_q       <= tv_d;
         tl_q       <= tl_d;
         te_q       <= te_d;
         ta_q       <= ta_d;
         up_valid_q <= up_valid_d;
         up_lvl_q   <= up_lvl_d;
         up_id_q    <= up_id_d;
         dn_valid_q <= dn_valid_d;
         dn_mask_q  <= dn_mask_d;
         dn_lvl_q   <= dn_lvl_d;
         dn_id_q    <= dn_id_d;
         err_q      <= err_d;
         err_id_q   <= err_id_d;
      end
   end

   assign up_valid_o = up_valid_q;
   assign up_lvl_o   = up_lvl_q;
   assign up_id_o    = up_id_q;
   assign dn_valid_o = dn_valid_q;
   assign dn_mask_o  = dn_mask_q;
   assign dn_lvl_o   = dn_lvl_q;
   assign dn_id_o    = dn_id_q;
   assign err_o      = err_q;
   assign err_id_o   = err_id_q;
endmodule
